rptr_empty: RTL and testbench

Read-side pointer and empty-flag generator for the dual-clock FIFO, running entirely in the read clock domain. It produces the gray-coded read pointer consumed by the read-to-write synchroniser. It also produces the binary RAM read address. It compares its next pointer against the write pointer already synchronised into the read domain to produce a registered, pessimistic `rempty` flag, plus a sticky underflow error.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/rptr_empty.sv | 106 ++++++++++
 tb/tb_rptr_empty.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer blocks: the default
// address width and gray/binary conversion helpers used by both the read-side
// and write-side pointer logic.
package fifo_pkg;

    // Default RAM address width; the FIFO depth is 2**ADRRSIZE_DEF.
    localparam int ADRRSIZE_DEF = 3;

    // Widest pointer the helpers handle. Callers zero-extend narrower
    // pointers to this width and truncate the result back to their own width.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    // Binary to reflected gray code. Zero-extended upper bits stay zero, so
    // the result is correct for any pointer width up to PTR_MAX_W.
    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    // Gray to binary by prefix XOR from the MSB down. Zero upper bits
    // contribute nothing, so narrower pointers convert correctly.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty.sv
// Read-side pointer and empty-flag generator for the dual-clock FIFO.
// Runs entirely in the rclk domain. It keeps a binary read pointer and drives
// the RAM read address and a flopped gray pointer for the read-to-write
// synchroniser. It also produces a registered pessimistic empty flag and a
// sticky underflow flag.
// Optional feature: define RPTR_LEVEL_EN to add the rlevel occupancy output
// and the ralmost_empty flag.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADRRSIZE  = ADRRSIZE_DEF,
    parameter int AE_THRESH = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADRRSIZE:0]   rq2_wptr,
    output logic [ADRRSIZE-1:0] raddr,
    output logic [ADRRSIZE:0]   rptr_gray,
    output logic                rempty,
    output logic                runderflow
`ifdef RPTR_LEVEL_EN
    ,
    output logic [ADRRSIZE:0]   rlevel,
    output logic                ralmost_empty
`endif
);

    localparam int PTR_W = ADRRSIZE + 1;

    logic [PTR_W-1:0] rbin_q;
    logic [PTR_W-1:0] rbin_d;
    logic [PTR_W-1:0] rgray_q;
    logic [PTR_W-1:0] rgray_d;
    logic             rempty_q;
    logic             rempty_d;
    logic             runderflow_q;
    logic             runderflow_d;
    logic             rd_ok;

    // Advance the pointer only on a read that finds data. The empty
    // comparison uses the next gray pointer, so the flag rises on the same
    // edge that consumes the last entry.
    always_comb begin
        rd_ok        = rinc & ~rempty_q;
        rbin_d       = rbin_q + PTR_W'(rd_ok);
        rgray_d      = PTR_W'(bin2gray(PTR_MAX_W'(rbin_d)));
        rempty_d     = (rgray_d == rq2_wptr);
        runderflow_d = runderflow_q | (rinc & rempty_q);
    end

    // Pointer, empty and underflow registers. Reset wins over any read.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rgray_q      <= '0;
            rempty_q     <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rgray_q      <= rgray_d;
            rempty_q     <= rempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    // rptr_gray crosses domains, so it is a bare flop output.
    assign raddr      = rbin_q[ADRRSIZE-1:0];
    assign rptr_gray  = rgray_q;
    assign rempty     = rempty_q;
    assign runderflow = runderflow_q;

`ifdef RPTR_LEVEL_EN
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] rlevel_q;
    logic [PTR_W-1:0] rlevel_d;
    logic             ralmost_q;
    logic             ralmost_d;

    // Occupancy against the next read pointer keeps it aligned with rempty.
    always_comb begin
        wbin      = PTR_W'(gray2bin(PTR_MAX_W'(rq2_wptr)));
        rlevel_d  = wbin - rbin_d;
        ralmost_d = (32'(rlevel_d) <= 32'(AE_THRESH));
    end

    // Level and almost-empty registers; reset reports an empty FIFO.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rlevel_q  <= '0;
            ralmost_q <= 1'b1;
        end else begin
            rlevel_q  <= rlevel_d;
            ralmost_q <= ralmost_d;
        end
    end

    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_q;
`else
    // The threshold only matters for the level feature.
    logic unused_ae_thresh;
    assign unused_ae_thresh = (AE_THRESH != 0);
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Directed testbench for rptr_empty with ADRRSIZE=3 and AE_THRESH=1.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at that same point.
module tb_rptr_empty;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic [3:0] rq2_wptr;
    logic [2:0] raddr;
    logic [3:0] rptr_gray;
    logic       rempty;
    logic       runderflow;
`ifdef RPTR_LEVEL_EN
    logic [3:0] rlevel;
    logic       ralmost_empty;
`endif

    int checks = 0;
    int errors = 0;

    rptr_empty #(.ADRRSIZE(3), .AE_THRESH(1)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr_gray  (rptr_gray),
        .rempty     (rempty),
        .runderflow (runderflow)
`ifdef RPTR_LEVEL_EN
        ,
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [3:0] g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0; rinc = 1'b1; rq2_wptr = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty cyc%0d got %b want 1", i, rempty); end
            checks++; if (rptr_gray !== 4'b0000) begin errors++; $display("FAIL reset_gray cyc%0d got %b want 0000", i, rptr_gray); end
            checks++; if (raddr !== 3'd0) begin errors++; $display("FAIL reset_raddr cyc%0d got %0d want 0", i, raddr); end
            checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL reset_underflow cyc%0d got %b want 0", i, runderflow); end
`ifdef RPTR_LEVEL_EN
            checks++; if (rlevel !== 4'd0 || ralmost_empty !== 1'b1) begin errors++; $display("FAIL reset_level cyc%0d got %0d/%b want 0/1", i, rlevel, ralmost_empty); end
`endif
        end
        rrst_n = 1'b1; rinc = 1'b0; rq2_wptr = 4'b0000;
        step();
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL post_reset_rempty got %b want 1", rempty); end
    endtask

    task automatic test_single();
        rq2_wptr = 4'b0001;
        step();
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL single_notempty got %b want 0", rempty); end
        checks++; if (raddr !== 3'd0) begin errors++; $display("FAIL single_raddr0 got %0d want 0", raddr); end
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (raddr !== 3'd1) begin errors++; $display("FAIL single_raddr got %0d want 1", raddr); end
        checks++; if (rptr_gray !== 4'b0001) begin errors++; $display("FAIL single_gray got %b want 0001", rptr_gray); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", rempty); end
        step();
        checks++; if (raddr !== 3'd1) begin errors++; $display("FAIL single_hold got %0d want 1", raddr); end
    endtask

    task automatic test_drain();
        rrst_n = 1'b0; rinc = 1'b0; rq2_wptr = 4'b1100;
        step();
        rrst_n = 1'b1;
        step();
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL drain_start_empty got %b want 0", rempty); end
        checks++; if (raddr !== 3'd0) begin errors++; $display("FAIL drain_start_raddr got %0d want 0", raddr); end
`ifdef RPTR_LEVEL_EN
        checks++; if (rlevel !== 4'd8) begin errors++; $display("FAIL drain_start_level got %0d want 8", rlevel); end
`endif
        rinc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++; if (raddr !== 3'(k)) begin errors++; $display("FAIL drain_raddr rd%0d got %0d want %0d", k, raddr, k % 8); end
            checks++; if (rempty !== (k == 8)) begin errors++; $display("FAIL drain_empty rd%0d got %b want %b", k, rempty, (k == 8)); end
            checks++; if (rptr_gray !== g(k)) begin errors++; $display("FAIL drain_gray rd%0d got %b want %b", k, rptr_gray, g(k)); end
`ifdef RPTR_LEVEL_EN
            checks++; if (rlevel !== 4'(8 - k)) begin errors++; $display("FAIL drain_level rd%0d got %0d want %0d", k, rlevel, 8 - k); end
`endif
        end
        checks++; if (rptr_gray !== 4'b1100) begin errors++; $display("FAIL drain_end_gray got %b want 1100", rptr_gray); end
    endtask

    task automatic test_underflow();
        // rinc is still high and the FIFO is empty after the drain.
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uflow_flag cyc%0d got %b want 1", i, runderflow); end
            checks++; if (raddr !== 3'd0 || rptr_gray !== 4'b1100) begin errors++; $display("FAIL uflow_ptr cyc%0d got %0d/%b want 0/1100", i, raddr, rptr_gray); end
            checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL uflow_empty cyc%0d got %b want 1", i, rempty); end
        end
        rinc = 1'b0;
        step();
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uflow_sticky got %b want 1", runderflow); end
        // Reset mid-stream with a nonzero write pointer still reports empty.
        rrst_n = 1'b0; rinc = 1'b1;
        step();
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uflow_clear got %b want 0", runderflow); end
        checks++; if (rempty !== 1'b1 || rptr_gray !== 4'b0000) begin errors++; $display("FAIL uflow_rst_state got %b/%b want 1/0000", rempty, rptr_gray); end
        rinc = 1'b0;
    endtask

    task automatic test_wrap();
        rrst_n = 1'b0; rq2_wptr = 4'b0000; rinc = 1'b0;
        step();
        rrst_n = 1'b1; rq2_wptr = g(1);
        step();
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL wrap_start_empty got %b want 0", rempty); end
        rinc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            rq2_wptr = (k >= 15) ? 4'b0000 : g(k + 1);
            step();
            checks++; if (rptr_gray !== g(k)) begin errors++; $display("FAIL wrap_gray rd%0d got %b want %b", k, rptr_gray, g(k)); end
            checks++; if (rempty !== (k == 16)) begin errors++; $display("FAIL wrap_empty rd%0d got %b want %b", k, rempty, (k == 16)); end
`ifdef RPTR_LEVEL_EN
            checks++; if (rlevel !== ((k == 16) ? 4'd0 : 4'd1)) begin errors++; $display("FAIL wrap_level rd%0d got %0d want %0d", k, rlevel, (k == 16) ? 0 : 1); end
`endif
        end
        rinc = 1'b0;
        checks++; if (rptr_gray !== 4'b0000 || raddr !== 3'd0) begin errors++; $display("FAIL wrap_end got %b/%0d want 0000/0", rptr_gray, raddr); end
    endtask

    task automatic test_almost_empty();
        rrst_n = 1'b0; rinc = 1'b0; rq2_wptr = 4'b0011;
        step();
        rrst_n = 1'b1;
        step();
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL ae_start_empty got %b want 0", rempty); end
`ifdef RPTR_LEVEL_EN
        checks++; if (rlevel !== 4'd2 || ralmost_empty !== 1'b0) begin errors++; $display("FAIL ae_level2 got %0d/%b want 2/0", rlevel, ralmost_empty); end
`endif
        rinc = 1'b1;
        step();
        checks++; if (rempty !== 1'b0 || raddr !== 3'd1) begin errors++; $display("FAIL ae_rd1 got %b/%0d want 0/1", rempty, raddr); end
`ifdef RPTR_LEVEL_EN
        checks++; if (rlevel !== 4'd1 || ralmost_empty !== 1'b1) begin errors++; $display("FAIL ae_level1 got %0d/%b want 1/1", rlevel, ralmost_empty); end
`endif
        step();
        rinc = 1'b0;
        checks++; if (rempty !== 1'b1 || raddr !== 3'd2) begin errors++; $display("FAIL ae_rd2 got %b/%0d want 1/2", rempty, raddr); end
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL ae_no_uflow got %b want 0", runderflow); end
`ifdef RPTR_LEVEL_EN
        checks++; if (rlevel !== 4'd0 || ralmost_empty !== 1'b1) begin errors++; $display("FAIL ae_level0 got %0d/%b want 0/1", rlevel, ralmost_empty); end
`endif
    endtask

    initial begin
        rrst_n = 1'b0;
        rinc = 1'b0;
        rq2_wptr = 4'b0000;
        test_reset();
        test_single();
        test_drain();
        test_underflow();
        test_wrap();
        test_almost_empty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
